// File: rtl/pipe_adder.sv
// Pipelined N-bit two's-complement adder with valid/ready streaming ports.
// The carry chain is cut into STAGES chunks, one chunk resolved per register stage.
module pipe_adder #(
    parameter int N      = 8,
    parameter int STAGES = 2,
    parameter int SAT    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] S,
    output logic         co,
    output logic         ov
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    logic         v_q [STAGES];
    logic         v_d [STAGES];
    logic [N-1:0] a_q [STAGES];
    logic [N-1:0] a_d [STAGES];
    logic [N-1:0] b_q [STAGES];
    logic [N-1:0] b_d [STAGES];
    logic [N-1:0] s_q [STAGES];
    logic [N-1:0] s_d [STAGES];
    logic         c_q [STAGES];
    logic         c_d [STAGES];
    logic         ov_q;
    logic         ov_d;

    logic         src_v [STAGES];
    logic [N-1:0] src_a [STAGES];
    logic [N-1:0] src_b [STAGES];
    logic [N-1:0] src_s [STAGES];
    logic         src_c [STAGES];

    logic [W:0]   part;
    logic         adv;

    assign adv     = ~v_q[L] | m_ready;
    assign s_ready = adv & ~rst;
    assign m_valid = v_q[L];
    assign S       = s_q[L];
    assign co      = c_q[L];
    assign ov      = ov_q;

    // Stage k consumes the register of stage k-1; stage 0 consumes the input port.
    always_comb begin
        src_v[0] = s_valid;
        src_a[0] = A;
        src_b[0] = B;
        src_s[0] = '0;
        src_c[0] = ci;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
    end

    always_comb begin
        part = '0;
        ov_d = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = src_v[k];
            a_d[k] = src_a[k];
            b_d[k] = src_b[k];
            s_d[k] = src_s[k];
            part   = {1'b0, src_a[k][k*W +: W]}
                   + {1'b0, src_b[k][k*W +: W]}
                   + {{W{1'b0}}, src_c[k]};
            s_d[k][k*W +: W] = part[W-1:0];
            c_d[k] = part[W];
        end
        ov_d = (src_a[L][N-1] == src_b[L][N-1])
             & (s_d[L][N-1] != src_a[L][N-1]);
        // Clamp only the sum; co and ov stay unclamped.
        if (SAT != 0 && ov_d) begin
            s_d[L] = src_a[L][N-1] ? {1'b1, {(N-1){1'b0}}}
                                   : {1'b0, {(N-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            ov_q <= ov_d;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: several widths/depths/saturation modes driven in
// lockstep, each checked by its own scoreboard queue against a flat adder model.
module tb_pipe_adder;

    localparam int NI = 9;
    localparam int NP [NI] = '{8, 8, 8, 8, 8, 16, 16, 16, 16};
    localparam int SP [NI] = '{2, 2, 1, 4, 8, 1, 2, 4, 8};
    localparam int TP [NI] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        m_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        ci_in;

    logic        s_ready_w [NI];
    logic        m_valid_w [NI];
    logic [15:0] s_w [NI];
    logic        co_w [NI];
    logic        ov_w [NI];

    logic [17:0] sbq [NI][$];
    int          acc_cnt [NI];
    int          checks;
    int          errors;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NG = NP[g];
        logic [NG-1:0] s_o;
        logic          sr_o;
        logic          mv_o;
        logic          co_o;
        logic          ov_o;
        pipe_adder #(.N(NG), .STAGES(SP[g]), .SAT(TP[g])) u_dut (
            .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr_o),
            .A(a_in[NG-1:0]), .B(b_in[NG-1:0]), .ci(ci_in),
            .m_valid(mv_o), .m_ready(m_ready), .S(s_o),
            .co(co_o), .ov(ov_o)
        );
        assign s_ready_w[g] = sr_o;
        assign m_valid_w[g] = mv_o;
        assign s_w[g]       = 16'(s_o);
        assign co_w[g]      = co_o;
        assign ov_w[g]      = ov_o;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] model(input int n, input int sat,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic c);
        logic [16:0] mask;
        logic [16:0] full;
        logic [15:0] s;
        logic        sa;
        logic        co_m;
        logic        ov_m;
        mask = (17'd1 << n) - 17'd1;
        full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 17'(c);
        co_m = full[n];
        s    = full[15:0] & mask[15:0];
        sa   = a[n-1];
        ov_m = (sa == b[n-1]) && (s[n-1] != sa);
        if (sat != 0 && ov_m)
            s = sa ? 16'(17'd1 << (n - 1)) : 16'(mask >> 1);
        return {ov_m, co_m, s};
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs,
                       input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] out_of(input int i);
        return {ov_w[i], co_w[i], s_w[i]};
    endfunction

    task automatic cyc(input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic c,
                       input logic mr);
        logic [17:0] e;
        s_valid = v;
        a_in    = a;
        b_in    = b;
        ci_in   = c;
        m_ready = mr;
        #1;
        for (int i = 0; i < NI; i++) begin
            if (m_valid_w[i] && m_ready) begin
                if (sbq[i].size() == 0) begin
                    chk($sformatf("spurious_u%0d", i), 18'(m_valid_w[i]), 18'(0));
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("sb_u%0d", i), out_of(i), e);
                end
            end
            if (s_valid && s_ready_w[i]) begin
                sbq[i].push_back(model(NP[i], TP[i], a, b, c));
                acc_cnt[i]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic drained(input string tag);
        for (int i = 0; i < NI; i++)
            chk($sformatf("%s_u%0d", tag, i), 18'(sbq[i].size()), 18'(0));
    endtask

    task automatic one(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic c,
                       input logic [17:0] e0, input logic [17:0] e1);
        cyc(1'b1, a, b, c, 1'b1);
        chk({tag, "_lat"}, 18'(m_valid_w[0]), 18'(0));
        cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        chk({tag, "_mv"}, 18'(m_valid_w[0]), 18'(1));
        chk(tag, out_of(0), e0);
        chk({tag, "_sat"}, out_of(1), e1);
    endtask

    function automatic int min_acc();
        int m;
        m = acc_cnt[0];
        for (int i = 1; i < NI; i++) if (acc_cnt[i] < m) m = acc_cnt[i];
        return m;
    endfunction

    initial begin
        logic [17:0] held;
        int          cnt;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        a_in    = '0;
        b_in    = '0;
        ci_in   = 1'b0;
        for (int i = 0; i < NI; i++) acc_cnt[i] = 0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_sready", 18'(s_ready_w[0]), 18'(0));
        chk("rst_mvalid", 18'(m_valid_w[0]), 18'(0));
        chk("rst_out", out_of(0), 18'(0));
        rst = 1'b0;
        #1;
        chk("rel_sready", 18'(s_ready_w[0]), 18'(1));

        one("add5_10", 16'd5, 16'd10, 1'b0, {2'b00, 16'h0F}, {2'b00, 16'h0F});
        one("add5_10c", 16'd5, 16'd10, 1'b1, {2'b00, 16'h10}, {2'b00, 16'h10});
        one("add30_m10", 16'd30, 16'hF6, 1'b0, {2'b01, 16'h14}, {2'b01, 16'h14});
        one("ovpos", 16'd127, 16'd1, 1'b0, {2'b10, 16'h80}, {2'b10, 16'h7F});
        one("ovneg", 16'h80, 16'hFF, 1'b0, {2'b11, 16'h7F}, {2'b11, 16'h80});
        idle(20);
        drained("dir_drain");

        for (int i = 0; i < 6; i++) begin
            if (i < 4)
                cyc(1'b1, 16'(i*3+1), 16'(i*37+200), 1'(i%2), 1'b1);
            else
                cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
            if (i == 0 || i == 5) begin
                chk($sformatf("stream_gap%0d", i), 18'(m_valid_w[0]), 18'(0));
            end else begin
                chk($sformatf("stream_mv%0d", i), 18'(m_valid_w[0]), 18'(1));
                chk($sformatf("stream_s%0d", i), out_of(0),
                    model(8, 0, 16'((i-1)*3+1), 16'((i-1)*37+200), 1'((i-1)%2)));
            end
        end
        idle(20);

        cyc(1'b1, 16'd11, 16'd22, 1'b0, 1'b1);
        cyc(1'b1, 16'd33, 16'd44, 1'b1, 1'b1);
        held = out_of(0);
        chk("bp_first", held, model(8, 0, 16'd11, 16'd22, 1'b0));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'd55, 16'd66, 1'b0, 1'b0);
            chk($sformatf("bp_sready%0d", i), 18'(s_ready_w[0]), 18'(0));
            chk($sformatf("bp_hold%0d", i), out_of(0), held);
        end
        m_ready = 1'b1;
        #1;
        chk("bp_resume", 18'(s_ready_w[0]), 18'(1));
        idle(20);
        drained("bp_drain");

        cyc(1'b1, 16'd7, 16'd8, 1'b0, 1'b1);
        cyc(1'b1, 16'd9, 16'd10, 1'b1, 1'b1);
        chk("pre_rst_mv", 18'(m_valid_w[0]), 18'(1));
        rst = 1'b1;
        #1;
        chk("midrst_mv", 18'(m_valid_w[0]), 18'(0));
        chk("midrst_out", out_of(0), 18'(0));
        chk("midrst_sready", 18'(s_ready_w[0]), 18'(0));
        for (int i = 0; i < NI; i++) sbq[i].delete();
        cyc(1'b1, 16'd1, 16'd2, 1'b0, 1'b1);
        rst = 1'b0;
        idle(1);
        chk("post_rst_mv", 18'(m_valid_w[0]), 18'(0));
        idle(12);

        for (int i = 0; i < NI; i++) acc_cnt[i] = 0;
        cnt = 0;
        while (min_acc() < 1000 && cnt < 20000) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                1'($urandom), $urandom_range(0, 9) < 7);
            cnt++;
        end
        chk("rand_budget", 18'(cnt < 20000), 18'(1));
        idle(30);
        drained("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
